// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressable little-endian data memory
// with synchronous stores, asynchronous sign-extending loads and write-back pass-through.
module mem_stage #(
    parameter int NB_ADDR   = 32,
    parameter int NB_DATA   = 32,
    parameter int NB_PC     = 32,
    parameter int NB_REG    = 5,
    parameter int MEM_BYTES = 128
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic               i_MEM_word_en,
    input  logic               i_MEM_halfword_en,
    input  logic               i_MEM_byte_en,
    input  logic               i_MEM_branch,
    input  logic               i_MEM_zero,
    input  logic [NB_PC-1:0]   i_MEM_branch_addr,
    input  logic [NB_ADDR-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_write_data,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    output logic [NB_DATA-1:0] o_MEM_mem_data,
    output logic [NB_REG-1:0]  o_MEM_selected_reg,
    output logic [NB_ADDR-1:0] o_MEM_alu_result,
    output logic [NB_PC-1:0]   o_MEM_branch_addr,
    output logic               o_MEM_branch_zero,
    output logic               o_MEM_reg_write,
    output logic               o_MEM_mem_to_reg
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [7:0]    mem_d [MEM_BYTES];
    logic [AW-1:0] addr;
    logic [2:0]    nbytes;
    logic [7:0]    rd_b [4];

    // Width priority word > halfword > byte; alignment forced by clearing low address bits.
    always_comb begin
        addr   = i_MEM_alu_result[AW-1:0];
        nbytes = 3'd0;
        if (i_MEM_word_en) begin
            nbytes    = 3'd4;
            addr[1:0] = 2'b00;
        end else if (i_MEM_halfword_en) begin
            nbytes  = 3'd2;
            addr[0] = 1'b0;
        end else if (i_MEM_byte_en) begin
            nbytes = 3'd1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (i_MEM_mem_write) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes)
                    mem_d[addr + AW'(k)] = i_MEM_write_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_BYTES; i++)
                mem_q[i] <= 8'h00;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see pre-edge contents, so a same-cycle store is not visible until the next cycle.
    always_comb begin
        for (int k = 0; k < 4; k++)
            rd_b[k] = mem_q[addr + AW'(k)];
        o_MEM_mem_data = '0;
        if (i_MEM_mem_read && i_reset) begin
            case (nbytes)
                3'd4:    o_MEM_mem_data = NB_DATA'({rd_b[3], rd_b[2], rd_b[1], rd_b[0]});
                3'd2:    o_MEM_mem_data = NB_DATA'($signed({rd_b[1], rd_b[0]}));
                3'd1:    o_MEM_mem_data = NB_DATA'($signed(rd_b[0]));
                default: o_MEM_mem_data = '0;
            endcase
        end
    end

    assign o_MEM_selected_reg = i_MEM_selected_reg;
    assign o_MEM_alu_result   = i_MEM_alu_result;
    assign o_MEM_branch_addr  = i_MEM_branch_addr;
    assign o_MEM_branch_zero  = i_MEM_branch & i_MEM_zero;
    assign o_MEM_reg_write    = i_MEM_reg_write;
    assign o_MEM_mem_to_reg   = i_MEM_mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-array reference model,
// preceded by the directed reset, store/load, branch and edge scenarios.
module tb_mem_stage;

    localparam int MEM = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write, mem_to_reg, mem_read, mem_write;
    logic        word_en, half_en, byte_en, branch, zero;
    logic [31:0] branch_addr, alu_result, write_data;
    logic [4:0]  sel_reg;
    logic [31:0] mem_data, alu_out, baddr_out;
    logic [4:0]  sel_out;
    logic        bz_out, rw_out, m2r_out;

    int          checks   = 0;
    int          failures = 0;
    int          ref_mem [MEM];
    logic        hold_pt  = 1'b0;
    logic [31:0] last_ld;

    always #5 clk = ~clk;

    mem_stage #(.NB_ADDR(32), .NB_DATA(32), .NB_PC(32), .NB_REG(5), .MEM_BYTES(MEM)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_MEM_reg_write(reg_write), .i_MEM_mem_to_reg(mem_to_reg),
        .i_MEM_mem_read(mem_read), .i_MEM_mem_write(mem_write),
        .i_MEM_word_en(word_en), .i_MEM_halfword_en(half_en), .i_MEM_byte_en(byte_en),
        .i_MEM_branch(branch), .i_MEM_zero(zero),
        .i_MEM_branch_addr(branch_addr), .i_MEM_alu_result(alu_result),
        .i_MEM_write_data(write_data), .i_MEM_selected_reg(sel_reg),
        .o_MEM_mem_data(mem_data), .o_MEM_selected_reg(sel_out),
        .o_MEM_alu_result(alu_out), .o_MEM_branch_addr(baddr_out),
        .o_MEM_branch_zero(bz_out), .o_MEM_reg_write(rw_out), .o_MEM_mem_to_reg(m2r_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input logic w, input logic h, input logic b);
        return w ? 4 : h ? 2 : b ? 1 : 0;
    endfunction

    function automatic int base_of(input logic [31:0] a, input int n);
        int x;
        x = int'(a % 32'(MEM));
        if (n > 1) x = x - (x % n);
        return x;
    endfunction

    function automatic logic [31:0] ref_load(input logic rd, input logic w, input logic h,
                                             input logic b, input logic [31:0] a, input logic rst);
        int     n, base;
        longint v;
        n = width_of(w, h, b);
        if (!rd || n == 0 || !rst) return 32'h0;
        base = base_of(a, n);
        v = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + ref_mem[(base + k) % MEM];
        if (n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        return v[31:0];
    endfunction

    task automatic op(input logic rd, input logic wr, input logic w, input logic h, input logic b,
                      input logic [31:0] a, input logic [31:0] wd, input logic rst);
        logic [31:0] exp_ld;
        int          n, base;
        @(negedge clk);
        rst_n = rst; mem_read = rd; mem_write = wr;
        word_en = w; half_en = h; byte_en = b;
        alu_result = a; write_data = wd;
        if (!hold_pt) begin
            reg_write   = 1'($urandom); mem_to_reg = 1'($urandom);
            branch      = 1'($urandom); zero       = 1'($urandom);
            branch_addr = $urandom;     sel_reg    = 5'($urandom);
        end
        exp_ld = ref_load(rd, w, h, b, a, rst);
        #2;
        last_ld = mem_data;
        chk("load", mem_data, exp_ld);
        chk("branch_zero", 32'(bz_out), 32'((branch === 1'b1 && zero === 1'b1) ? 1 : 0));
        chk("alu_result", alu_out, a);
        chk("branch_addr", baddr_out, branch_addr);
        chk("selected_reg", 32'(sel_out), 32'(sel_reg));
        chk("reg_write", 32'(rw_out), 32'(reg_write));
        chk("mem_to_reg", 32'(m2r_out), 32'(mem_to_reg));
        @(posedge clk);
        n = width_of(w, h, b);
        if (!rst) begin
            for (int i = 0; i < MEM; i++) ref_mem[i] = 0;
        end else if (wr && n > 0) begin
            base = base_of(a, n);
            for (int k = 0; k < n; k++) ref_mem[(base + k) % MEM] = int'((wd >> (8 * k)) & 32'hFF);
        end
    endtask

    initial begin
        logic [1:0] bz;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 0;
        rst_n = 1'b0; reg_write = 0; mem_to_reg = 0; mem_read = 0; mem_write = 0;
        word_en = 0; half_en = 0; byte_en = 0; branch = 0; zero = 0;
        branch_addr = 0; alu_result = 0; write_data = 0; sel_reg = 0;

        // reset held two cycles, then released
        op(0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        op(1, 0, 1, 0, 0, 32'd8, 32'd0, 0);
        op(1, 0, 1, 0, 0, 32'd8, 32'd0, 1);
        chk("reset_word8", last_ld, 32'h0000_0000);

        // byte store/load with sign extension
        op(0, 1, 0, 0, 1, 32'd10, 32'd14, 1);
        op(1, 0, 0, 0, 1, 32'd10, 32'd0, 1);
        chk("byte10", last_ld, 32'd14);
        op(1, 0, 1, 0, 0, 32'd8, 32'd0, 1);
        chk("word8", last_ld, 32'h000E_0000);
        op(0, 1, 0, 0, 1, 32'd11, 32'h80, 1);
        op(1, 0, 0, 0, 1, 32'd11, 32'd0, 1);
        chk("byte_sext", last_ld, 32'hFFFF_FF80);

        // word store, halfword/word loads with forced alignment
        op(0, 1, 1, 0, 0, 32'd0, 32'd257, 1);
        op(1, 0, 0, 1, 0, 32'd0, 32'd0, 1);
        chk("half0", last_ld, 32'd257);
        op(1, 0, 0, 1, 0, 32'd3, 32'd0, 1);
        chk("half3", last_ld, 32'd0);
        op(1, 0, 1, 0, 0, 32'd1, 32'd0, 1);
        chk("word1", last_ld, 32'd257);

        // partial-write isolation
        op(0, 1, 1, 0, 0, 32'd4, 32'hAABB_CCDD, 1);
        op(0, 1, 0, 1, 0, 32'd6, 32'h0000_1234, 1);
        op(1, 0, 1, 0, 0, 32'd4, 32'd0, 1);
        chk("partial", last_ld, 32'h1234_CCDD);

        // branch combinations and fixed pass-through values
        hold_pt = 1'b1;
        branch_addr = 32'hF; sel_reg = 5'd4; reg_write = 1; mem_to_reg = 1;
        for (int i = 0; i < 4; i++) begin
            bz = 2'(i);
            branch = bz[1]; zero = bz[0];
            op(0, 0, 0, 0, 0, 32'h55, 32'd0, 1);
            chk("bz_combo", 32'(bz_out), 32'((i == 3) ? 1 : 0));
        end
        hold_pt = 1'b0;

        // no width enable, address wrap, read-during-write
        op(1, 0, 0, 0, 0, 32'd4, 32'd0, 1);
        chk("no_width", last_ld, 32'd0);
        op(0, 1, 0, 0, 1, 32'(MEM + 2), 32'h5A, 1);
        op(1, 0, 0, 0, 1, 32'd2, 32'd0, 1);
        chk("wrap", last_ld, 32'h5A);
        op(1, 1, 1, 0, 0, 32'd12, 32'h1122_3344, 1);
        chk("rw_old", last_ld, 32'd0);
        op(1, 0, 1, 0, 0, 32'd12, 32'd0, 1);
        chk("rw_new", last_ld, 32'h1122_3344);

        // reset overrides a pending store and clears earlier data
        op(0, 1, 1, 0, 0, 32'd16, 32'hDEAD_BEEF, 0);
        op(1, 0, 1, 0, 0, 32'd16, 32'd0, 1);
        chk("rst_store", last_ld, 32'd0);
        op(1, 0, 1, 0, 0, 32'd12, 32'd0, 1);
        chk("rst_clear", last_ld, 32'd0);

        // randomized traffic, narrow address range to force overlap, occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
            op(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               a, $urandom, ($urandom_range(0, 49) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
